load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/mem_pkg.sv | 37 +++
 rtl/load_store_unit_load_extract.sv | 39 +++
 rtl/load_store_unit.sv | 158 +++++++++++++++
 tb/tb_load_store_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared memory-access types for decode and the load/store unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_t;

    typedef logic [1:0] lsu_state_t;

    localparam lsu_state_t IDLE = 2'd0;
    localparam lsu_state_t REQ  = 2'd1;
    localparam lsu_state_t WAIT = 2'd2;
    localparam lsu_state_t DONE = 2'd3;

    // Size code 3 is reserved and always treated as a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = off[0];
            2'd2:    bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_load_extract.sv
// ============================================================================
//  Module      : load_extract
//  Description : Selects the addressed byte/half of a bus word and extends it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_extract
    import mem_pkg::*;
(
    input  logic [31:0] i_bus_rdata,
    input  logic [1:0]  i_byte_off,
    input  mem_size_t   i_size,
    input  logic        i_signed,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_byte_off)
            2'd0:    w_byte = i_bus_rdata[7:0];
            2'd1:    w_byte = i_bus_rdata[15:8];
            2'd2:    w_byte = i_bus_rdata[23:16];
            default: w_byte = i_bus_rdata[31:24];
        endcase
        w_half = i_byte_off[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];

        case (i_size)
            BYTE:    o_result = {{24{i_signed & w_byte[7]}}, w_byte};
            HALF:    o_result = {{16{i_signed & w_half[15]}}, w_half};
            default: o_result = i_bus_rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
//  Module      : load_store_unit
//  Description : Single-outstanding load/store sequencer onto a 32-bit bus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic              mem_signed,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [31:0]       rdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
);

    lsu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    mem_size_t         size_q, size_d;
    logic              signed_q, signed_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              fault_q, fault_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [31:0]       w_load;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata_lanes;
    logic              w_in_req;

    load_extract u_load_extract (
        .i_bus_rdata (bus_rdata),
        .i_byte_off  (addr_q[1:0]),
        .i_size      (size_q),
        .i_signed    (signed_q),
        .o_result    (w_load)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        signed_d = signed_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        fault_d  = fault_q;
        rdata_d  = rdata_q;

        case (state_q)
            IDLE: begin
                if (start && (mem_read || mem_write)) begin
                    addr_d   = addr;
                    size_d   = mem_size_t'(mem_size);
                    signed_d = mem_signed;
                    wdata_d  = wdata;
                    we_d     = mem_write;
                    // Faulted accesses skip the bus and report through DONE.
                    if ((mem_read && mem_write) || is_misaligned(mem_size, addr[1:0])) begin
                        fault_d = 1'b1;
                        rdata_d = 32'd0;
                        state_d = DONE;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (bus_gnt) begin
                    state_d = we_q ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (bus_rvalid) begin
                    rdata_d = w_load;
                    state_d = DONE;
                end
            end
            default: begin
                fault_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            size_q   <= BYTE;
            signed_q <= 1'b0;
            wdata_q  <= 32'd0;
            we_q     <= 1'b0;
            fault_q  <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            fault_q  <= fault_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        case (size_q)
            BYTE: begin
                w_be          = 4'b0001 << addr_q[1:0];
                w_wdata_lanes = {4{wdata_q[7:0]}};
            end
            HALF: begin
                w_be          = addr_q[1] ? 4'b1100 : 4'b0011;
                w_wdata_lanes = {2{wdata_q[15:0]}};
            end
            default: begin
                w_be          = 4'b1111;
                w_wdata_lanes = wdata_q;
            end
        endcase
    end

    // Bus payload is held at zero outside REQ so it only ever reflects a live request.
    assign w_in_req  = (state_q == REQ);
    assign bus_req   = w_in_req;
    assign bus_we    = w_in_req & we_q;
    assign bus_addr  = w_in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign bus_be    = w_in_req ? w_be : 4'b0000;
    assign bus_wdata = w_in_req ? w_wdata_lanes : 32'd0;

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign fault = done & fault_q;
    assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Randomized self-checking bench for load_store_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_signed;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] rdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] ref_rdata   = 32'd0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_size   (mem_size),
        .mem_signed (mem_signed),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .rdata      (rdata),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference rules expressed as byte counts and shifts.
    function automatic int nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic bit ref_misaligned(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        return (int'(a[1:0]) % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] a);
        int v;
        v = ((1 << nbytes(sz)) - 1) << a[1:0];
        return v[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] w);
        if (sz == 2'd0) return {24'd0, w[7:0]} * 32'h0101_0101;
        if (sz == 2'd1) return {16'd0, w[15:0]} * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sgn,
                                             input logic [31:0] a, input logic [31:0] d);
        int          bits;
        logic [31:0] v;
        bits = 8 * nbytes(sz);
        v    = d >> (8 * a[1:0]);
        if (bits < 32) begin
            v = v & ((32'd1 << bits) - 32'd1);
            if (sgn && v[bits-1]) v = v - (32'd1 << bits);
        end
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_busy"},  busy,      0);
        check_val({tag, "_done"},  done,      0);
        check_val({tag, "_fault"}, fault,     0);
        check_val({tag, "_req"},   bus_req,   0);
        check_val({tag, "_we"},    bus_we,    0);
        check_val({tag, "_be"},    bus_be,    0);
        check_val({tag, "_addr"},  bus_addr,  0);
        check_val({tag, "_wdata"}, bus_wdata, 0);
        check_val({tag, "_rdata"}, rdata,     0);
    endtask

    task automatic check_payload(input bit wr, input logic [1:0] sz,
                                 input logic [31:0] a, input logic [31:0] wd);
        check_val("req",      bus_req,  1);
        check_val("req_busy", busy,     1);
        check_val("req_done", done,     0);
        check_val("bus_we",   bus_we,   wr);
        check_val("bus_addr", bus_addr, a & 32'hFFFF_FFFC);
        check_val("bus_be",   bus_be,   ref_be(sz, a));
        if (wr) check_val("bus_wdata", bus_wdata, ref_wdata(sz, wd));
    endtask

    task automatic do_access(input bit rd, input bit wr, input logic [1:0] sz, input bit sgn,
                             input logic [31:0] a, input logic [31:0] wd, input int gnt_dly,
                             input int rv_dly, input logic [31:0] brd, input bit noise);
        start = 1'b1; mem_read = rd; mem_write = wr; mem_size = sz;
        mem_signed = sgn; addr = a; wdata = wd;
        tick();
        start = 1'b0; mem_read = 1'($urandom); mem_write = 1'($urandom);
        addr = $urandom; wdata = $urandom; mem_size = 2'($urandom);

        if (!rd && !wr) begin
            check_val("ignored_busy", busy, 0);
            check_val("ignored_req",  bus_req, 0);
            return;
        end

        if ((rd && wr) || ref_misaligned(sz, a)) begin
            ref_rdata = 32'd0;
            check_val("fault_done",  done,    1);
            check_val("fault_flag",  fault,   1);
            check_val("fault_rdata", rdata,   0);
            check_val("fault_noreq", bus_req, 0);
            tick();
            check_val("fault_end_done", done, 0);
            check_val("fault_end_busy", busy, 0);
            return;
        end

        for (int i = 0; i < gnt_dly; i++) begin
            check_payload(wr, sz, a, wd);
            if (noise) begin
                start = 1'b1; mem_read = 1'($urandom); mem_write = 1'($urandom);
                mem_size = 2'($urandom); addr = $urandom;
                bus_rvalid = 1'b1; bus_rdata = $urandom;
            end
            tick();
            start = 1'b0; bus_rvalid = 1'b0;
        end
        bus_gnt = 1'b1;
        check_payload(wr, sz, a, wd);
        tick();
        bus_gnt = 1'b0;

        if (!wr) begin
            for (int i = 0; i < rv_dly; i++) begin
                check_val("wait_busy",  busy,    1);
                check_val("wait_done",  done,    0);
                check_val("wait_noreq", bus_req, 0);
                tick();
            end
            bus_rvalid = 1'b1; bus_rdata = brd;
            tick();
            bus_rvalid = 1'b0; bus_rdata = $urandom;
            ref_rdata = ref_load(sz, sgn, a, brd);
        end

        check_val("done",       done,  1);
        check_val("done_fault", fault, 0);
        check_val("done_rdata", rdata, ref_rdata);
        tick();
        check_val("post_done", done,  0);
        check_val("post_busy", busy,  0);
        check_val("hold_rdata", rdata, ref_rdata);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          kind;
        bit          rd, wr, sgn;
        logic [1:0]  sz;
        logic [31:0] a;

        rst_n = 1'b0; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        mem_size = 2'd0; mem_signed = 1'b0; addr = 32'd0; wdata = 32'd0;
        bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        tick();
        tick();
        check_reset_outputs("reset");
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        rst_n = 1'b1;
        tick();

        do_access(0, 1, 2'd0, 0, 32'h1003, 32'h0000_00AB, 0, 0, 32'd0, 0);
        do_access(1, 0, 2'd1, 1, 32'h2002, 32'd0, 0, 1, 32'h8001_1234, 0);
        do_access(1, 0, 2'd1, 0, 32'h2002, 32'd0, 0, 0, 32'h8001_1234, 0);
        do_access(1, 0, 2'd2, 0, 32'h3001, 32'd0, 0, 0, 32'd0, 0);
        do_access(0, 1, 2'd2, 0, 32'h5008, 32'hDEAD_BEEF, 5, 0, 32'd0, 1);
        do_access(1, 0, 2'd0, 1, 32'h4001, 32'd0, 2, 0, 32'h0000_8000, 1);
        do_access(1, 1, 2'd2, 0, 32'h6000, 32'd0, 0, 0, 32'd0, 0);
        do_access(0, 0, 2'd2, 0, 32'h6000, 32'd0, 0, 0, 32'd0, 0);
        do_access(1, 0, 2'd3, 0, 32'h7000, 32'd0, 0, 0, 32'd0, 0);

        // Reset during WAIT, then a late rvalid/gnt must be ignored.
        do_access(1, 0, 2'd2, 0, 32'h0000_0100, 32'd0, 0, 0, 32'h1234_5678, 0);
        start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'd2; addr = 32'h5000;
        tick();
        start = 1'b0; bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        check_val("rst_wait_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        ref_rdata = 32'd0;
        check_reset_outputs("rst_mid");
        rst_n = 1'b1; bus_rvalid = 1'b1; bus_gnt = 1'b1; bus_rdata = 32'hCAFE_F00D;
        tick();
        bus_rvalid = 1'b0; bus_gnt = 1'b0;
        check_reset_outputs("rst_late");
        tick();
        check_reset_outputs("rst_late2");

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            rd   = (kind == 0) ? 1'b1 : (kind == 1) ? 1'b0 : 1'($urandom);
            wr   = (kind == 0) ? 1'b1 : (kind == 1) ? 1'b0 : ~rd;
            sz   = 2'($urandom);
            sgn  = 1'($urandom);
            a    = $urandom;
            if ($urandom_range(0, 3) != 0 && sz != 2'd3)
                a = a & ~(32'(nbytes(sz)) - 32'd1);
            do_access(rd, wr, sz, sgn, a, $urandom, $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
